cdb_arbiter: RTL and testbench

//   Shares the single common data bus (CDB) between result producers: both ALUs fed by the

---
 rtl/cdb_arbiter_if.sv | 20 ++
 rtl/cdb_arbiter.sv | 84 ++++++++
 tb/tb_cdb_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer result requests and the registered CDB broadcast
interface cdb_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  localparam int SW        = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_value;
  logic [NUM_REQ*ROB_WIDTH-1:0]  req_tag;
  logic                          cdb_valid;
  logic [DATA_WIDTH-1:0]         cdb_value;
  logic [ROB_WIDTH-1:0]          cdb_tag;
  logic [SW-1:0]                 cdb_src;
  modport master (output req_valid, req_value, req_tag,
                  input  req_ready, cdb_valid, cdb_value, cdb_tag, cdb_src);
  modport slave  (input  req_valid, req_value, req_tag,
                  output req_ready, cdb_valid, cdb_value, cdb_tag, cdb_src);
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB arbiter, 1-entry slot per producer; define CDB_FIXED_PRIO_EN for fixed priority
module cdb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  localparam int SW        = $clog2(NUM_REQ)
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         flush_in,
  cdb_arbiter_if.slave bus
);
  logic [NUM_REQ-1:0]    full_q, full_d, grant, acc;
  logic [DATA_WIDTH-1:0] val_q [NUM_REQ];
  logic [ROB_WIDTH-1:0]  tag_q [NUM_REQ];
  logic [SW-1:0]         win;
  logic                  found, go, run;
  logic                  cdb_valid_q;
  logic [DATA_WIDTH-1:0] cdb_value_q;
  logic [ROB_WIDTH-1:0]  cdb_tag_q;
  logic [SW-1:0]         cdb_src_q;
  assign run = rdy_in & ~flush_in;
`ifdef CDB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (full_q[k]) begin
        win = SW'(k);
        found = 1'b1;
      end
  end
`else
  logic [SW-1:0] rr_q, rr_d, idx;
  // descending scan so the slot closest to rr_q is the last (winning) assignment
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = SW'((int'(rr_q) + k) % NUM_REQ);
      if (full_q[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
    rr_d = flush_in ? '0 : go ? (win == SW'(NUM_REQ-1) ? '0 : win + 1'b1) : rr_q;
  end
  always_ff @(posedge clk_in) rr_q <= rst_in ? '0 : rdy_in ? rr_d : rr_q;
`endif
  assign go = found & run;
  assign grant = go ? NUM_REQ'(1) << win : '0;
  assign bus.req_ready = {NUM_REQ{run}} & (~full_q | grant);
  assign acc = bus.req_valid & bus.req_ready;
  assign full_d = flush_in ? '0 : (full_q & ~grant) | acc;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      full_q <= '0;
      cdb_valid_q <= 1'b0;
      cdb_value_q <= '0;
      cdb_tag_q <= '0;
      cdb_src_q <= '0;
    end else if (rdy_in) begin
      full_q <= full_d;
      cdb_valid_q <= go;
      if (go) begin
        cdb_value_q <= val_q[win];
        cdb_tag_q <= tag_q[win];
        cdb_src_q <= win;
      end
    end
  end
  always_ff @(posedge clk_in)
    for (int i = 0; i < NUM_REQ; i++)
      if (acc[i]) begin
        val_q[i] <= bus.req_value[i*DATA_WIDTH +: DATA_WIDTH];
        tag_q[i] <= bus.req_tag[i*ROB_WIDTH +: ROB_WIDTH];
      end
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_value = cdb_value_q;
  assign bus.cdb_tag = cdb_tag_q;
  assign bus.cdb_src = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter (reset, single, round-robin/fixed, pause, flush)
module tb_cdb_arbiter;
  typedef struct packed {logic [31:0] v; logic [3:0] t; logic [1:0] s;} bc_t;
  logic clk = 1'b0;
  logic rst, rdy, flush;
  int checks = 0;
  int errors = 0;
  bc_t exp_q[$];
  bc_t got, e;
  cdb_arbiter_if bus ();
  cdb_arbiter dut (.clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush), .bus(bus));
  always #5 clk = ~clk;
  assign got = {bus.cdb_value, bus.cdb_tag, bus.cdb_src};
  function automatic bc_t mk(input logic [3:0] t, input logic [1:0] s);
    return '{32'h100 + 32'(t), t, s};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] v, input logic [3:0] t0, t1, t2);
    bus.req_valid = v;
    bus.req_tag = {t2, t1, t0};
    bus.req_value = {32'h100 + 32'(t2), 32'h100 + 32'(t1), 32'h100 + 32'(t0)};
  endtask
  task automatic apply_reset;
    rst = 1'b1;
    rdy = 1'b1;
    flush = 1'b0;
    drive(3'b000, 0, 0, 0);
    exp_q.delete();
    repeat (2) tick;
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    rdy = 1'b1;
    flush = 1'b0;
    drive(3'b111, 1, 2, 3);
    repeat (2) begin
      tick;
      checks++;
      if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.cdb_valid); end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b want 111", bus.req_ready); end
    exp_q.push_back(mk(1, 0));
    exp_q.push_back(mk(2, 1));
    exp_q.push_back(mk(3, 2));
    tick;
    drive(3'b000, 0, 0, 0);
    checks++;
    if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_first_cycle: got %b want 0", bus.cdb_valid); end
    repeat (4) begin
      tick;
      if (bus.cdb_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL reset_bcast: unexpected %h", got); end
        else begin
          e = exp_q.pop_front();
          if (got !== e) begin errors++; $display("FAIL reset_bcast: got %h want %h", got, e); end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL reset_drain: %0d left want 0", exp_q.size()); end
  endtask
  task automatic test_single;
    apply_reset;
    bus.req_valid = 3'b010;
    bus.req_tag = {4'd0, 4'd5, 4'd0};
    bus.req_value = {32'd0, 32'h0000_00AB, 32'd0};
    e = '{32'h0000_00AB, 4'd5, 2'd1};
    exp_q.push_back(e);
    tick;
    drive(3'b000, 0, 0, 0);
    checks++;
    if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", bus.cdb_valid); end
    tick;
    e = exp_q.pop_front();
    checks++;
    if ({bus.cdb_valid, got} !== {1'b1, e}) begin errors++; $display("FAIL single_bcast: got %b/%h want 1/%h", bus.cdb_valid, got, e); end
    tick;
    checks++;
    if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b want 0", bus.cdb_valid); end
  endtask
  task automatic test_round_robin;
    int cnt [3];
    logic [2:0] v, acc;
    apply_reset;
    cnt = '{0, 0, 0};
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(4'(i + 1), 2'(i % 3)));
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 3; i++) v[i] = cnt[i] < 2;
      drive(v, 4'(1 + 3*cnt[0]), 4'(2 + 3*cnt[1]), 4'(3 + 3*cnt[2]));
      #1 acc = v & bus.req_ready;
      if (v != 3'b000) begin
        checks++;
        if (acc == 3'b000) begin errors++; $display("FAIL rr_ready: cycle %0d ready %b valid %b", c, bus.req_ready, v); end
      end
      tick;
      for (int i = 0; i < 3; i++) if (acc[i]) cnt[i]++;
      if (c >= 1 && c <= 6) begin
        checks++;
        if (bus.cdb_valid !== 1'b1) begin errors++; $display("FAIL rr_valid: cycle %0d got %b want 1", c, bus.cdb_valid); end
      end
      if (bus.cdb_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rr_bcast: unexpected %h", got); end
        else begin
          e = exp_q.pop_front();
          if (got !== e) begin errors++; $display("FAIL rr_bcast: got %h want %h", got, e); end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rr_drain: %0d left want 0", exp_q.size()); end
  endtask
`ifdef CDB_FIXED_PRIO_EN
  task automatic test_fixed_prio;
    apply_reset;
    for (int i = 1; i <= 4; i++) exp_q.push_back(mk(4'(i), 0));
    exp_q.push_back(mk(9, 2));
    drive(3'b101, 1, 0, 9);
    tick;
    for (int c = 2; c <= 4; c++) begin
      drive(3'b001, 4'(c), 0, 0);
      tick;
      e = exp_q.pop_front();
      checks++;
      if ({bus.cdb_valid, got} !== {1'b1, e}) begin errors++; $display("FAIL prio_bcast: got %b/%h want 1/%h", bus.cdb_valid, got, e); end
    end
    drive(3'b000, 0, 0, 0);
    repeat (3) begin
      tick;
      if (bus.cdb_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL prio_tail: unexpected %h", got); end
        else begin
          e = exp_q.pop_front();
          if (got !== e) begin errors++; $display("FAIL prio_tail: got %h want %h", got, e); end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL prio_drain: %0d left want 0", exp_q.size()); end
  endtask
`endif
  task automatic test_pause;
    apply_reset;
    exp_q.push_back(mk(7, 2));
    exp_q.push_back(mk(8, 0));
    exp_q.push_back(mk(9, 2));
    drive(3'b100, 0, 0, 7);
    tick;
    drive(3'b101, 8, 0, 9);
    #1;
    checks++;
    if (bus.req_ready !== 3'b111) begin errors++; $display("FAIL pause_refill_ready: got %b want 111", bus.req_ready); end
    tick;
    e = exp_q.pop_front();
    checks++;
    if ({bus.cdb_valid, got} !== {1'b1, e}) begin errors++; $display("FAIL pause_pre: got %b/%h want 1/%h", bus.cdb_valid, got, e); end
    rdy = 1'b0;
    drive(3'b010, 0, 10, 0);
    #1;
    checks++;
    if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL pause_ready: got %b want 000", bus.req_ready); end
    repeat (3) begin
      tick;
      checks++;
      if ({bus.cdb_valid, got} !== {1'b1, mk(7, 2)}) begin errors++; $display("FAIL pause_frozen: got %b/%h want 1/%h", bus.cdb_valid, got, mk(7, 2)); end
    end
    rdy = 1'b1;
    drive(3'b000, 0, 0, 0);
    repeat (3) begin
      tick;
      if (bus.cdb_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL pause_bcast: unexpected %h", got); end
        else begin
          e = exp_q.pop_front();
          if (got !== e) begin errors++; $display("FAIL pause_bcast: got %h want %h", got, e); end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL pause_drain: %0d left want 0", exp_q.size()); end
  endtask
  task automatic test_flush;
    apply_reset;
    exp_q.push_back(mk(1, 0));
    drive(3'b001, 1, 0, 0);
    tick;
    drive(3'b011, 2, 3, 0);
    tick;
    e = exp_q.pop_front();
    checks++;
    if ({bus.cdb_valid, got} !== {1'b1, e}) begin errors++; $display("FAIL flush_pre: got %b/%h want 1/%h", bus.cdb_valid, got, e); end
    flush = 1'b1;
    drive(3'b100, 0, 0, 9);
    #1;
    checks++;
    if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL flush_ready: got %b want 000", bus.req_ready); end
    tick;
    flush = 1'b0;
    drive(3'b000, 0, 0, 0);
    checks++;
    if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.cdb_valid); end
    repeat (4) begin
      tick;
      checks++;
      if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_leftover: got %b/%h want 0", bus.cdb_valid, got); end
    end
    exp_q.push_back(mk(5, 0));
    exp_q.push_back(mk(6, 1));
    drive(3'b011, 5, 6, 0);
    tick;
    drive(3'b000, 0, 0, 0);
    repeat (3) begin
      tick;
      if (bus.cdb_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL flush_rr: unexpected %h", got); end
        else begin
          e = exp_q.pop_front();
          if (got !== e) begin errors++; $display("FAIL flush_rr: got %h want %h", got, e); end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL flush_drain: %0d left want 0", exp_q.size()); end
  endtask
  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    flush = 1'b0;
    drive(3'b000, 0, 0, 0);
    test_reset;
    test_single;
`ifdef CDB_FIXED_PRIO_EN
    test_fixed_prio;
`else
    test_round_robin;
`endif
    test_pause;
    test_flush;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
